// File: rtl/video_in_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : video_in_pkg                                                   |
// | Shared frame geometry, FSM state type and Wishbone CTI codes for the     |
// | video_in path.                                                           |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
package video_in_pkg;

  localparam int unsigned c_WIDTH_DEF  = 640;
  localparam int unsigned c_HEIGHT_DEF = 480;

  // Four packed pixels per 32-bit word.
  function automatic int unsigned frame_words(input int unsigned width, input int unsigned height);
    return (width * height) / 4;
  endfunction

  localparam int unsigned FRAME_WORDS = frame_words(c_WIDTH_DEF, c_HEIGHT_DEF);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB  = 3'b111;

endpackage : video_in_pkg
`default_nettype wire

// File: rtl/video_in_wb_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : video_in_wb_writer                                             |
// | Drains packed-pixel words from the video_in FIFO and writes them to the  |
// | frame buffer with Wishbone incrementing bursts. Optional statistics      |
// | outputs are enabled with `define VIDEO_IN_WB_STATS_EN.                   |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module video_in_wb_writer
  import video_in_pkg::*;
#(
  parameter int unsigned p_WIDTH  = c_WIDTH_DEF,
  parameter int unsigned p_HEIGHT = c_HEIGHT_DEF,
  parameter int unsigned p_BURST  = 8,
  parameter int unsigned p_FDEPTH = 6
) (
  input  logic                clk,
  input  logic                nRST,
  input  logic [31:0]         fifo_data,
  input  logic [p_FDEPTH-1:0] fifo_nb_words,
  output logic                fifo_r_e,
  input  logic [31:0]         base_addr,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [31:0]         wb_adr_o,
  output logic [31:0]         wb_dat_o,
  output logic [3:0]          wb_sel_o,
  output logic [2:0]          wb_cti_o,
  output logic [1:0]          wb_bte_o,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  output logic                frame_done,
  output logic                wb_error
`ifdef VIDEO_IN_WB_STATS_EN
  ,
  output logic [15:0]         frame_cnt,
  output logic [7:0]          err_cnt
`endif
);

  localparam int unsigned c_FRAME_WORDS = frame_words(p_WIDTH, p_HEIGHT);
  localparam int unsigned c_WCNT_W      = $clog2(c_FRAME_WORDS);
  localparam int unsigned c_BEAT_W      = $clog2(p_BURST);

  localparam logic [p_FDEPTH-1:0] c_BURST_LVL   = p_FDEPTH'(p_BURST);
  localparam logic [c_WCNT_W-1:0] c_LAST_WORD   = c_WCNT_W'(c_FRAME_WORDS - 1);
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT   = c_BEAT_W'(p_BURST - 1);
  localparam logic [c_BEAT_W-1:0] c_PENULT_BEAT = c_BEAT_W'(p_BURST - 2);

  state_t              r_state;
  logic                r_reload;
  logic [31:0]         r_ptr;
  logic [c_WCNT_W-1:0] r_wcnt;
  logic [c_BEAT_W-1:0] r_beat;
  logic [31:0]         w_ptr;

  // The first IDLE cycle after reset may also launch a burst, so the reload
  // value is forwarded to the address register in that same cycle.
  assign w_ptr    = r_reload ? base_addr : r_ptr;
  assign fifo_r_e = wb_ack_i & ~wb_err_i & (r_state == BURST);
  assign wb_dat_o = fifo_data;
  assign wb_sel_o = 4'hF;
  assign wb_bte_o = 2'b00;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_reload   <= 1'b1;
      r_ptr      <= '0;
      r_wcnt     <= '0;
      r_beat     <= '0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_cti_o   <= '0;
      frame_done <= 1'b0;
      wb_error   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_reload <= 1'b0;
          r_ptr    <= w_ptr;
          if (fifo_nb_words >= c_BURST_LVL) begin
            r_state  <= BURST;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_adr_o <= w_ptr;
            wb_cti_o <= CTI_INCR;
            r_beat   <= '0;
          end
        end
        BURST: begin
          if (wb_err_i) begin
            // Pointer and word count already reflect the last acked beat.
            r_state  <= IDLE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_cti_o <= '0;
            wb_error <= 1'b1;
          end else if (wb_ack_i) begin
            wb_adr_o <= wb_adr_o + 32'd4;
            r_beat   <= r_beat + 1'b1;
            if (r_wcnt == c_LAST_WORD) begin
              r_wcnt     <= '0;
              r_ptr      <= base_addr;
              frame_done <= 1'b1;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
              r_ptr  <= r_ptr + 32'd4;
            end
            if (r_beat == c_LAST_BEAT) begin
              r_state  <= IDLE;
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              wb_we_o  <= 1'b0;
              wb_cti_o <= '0;
            end else begin
              wb_cti_o <= (r_beat == c_PENULT_BEAT) ? CTI_EOB : CTI_INCR;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef VIDEO_IN_WB_STATS_EN
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if ((r_state == BURST) && wb_err_i && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule : video_in_wb_writer
`default_nettype wire

// File: tb/tb_video_in_wb_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_video_in_wb_writer                                          |
// | Scoreboard bench for video_in_wb_writer (reduced 64x16 frame).           |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_video_in_wb_writer;
  import video_in_pkg::*;

  localparam int unsigned c_W  = 64;
  localparam int unsigned c_H  = 16;
  localparam int unsigned c_B  = 8;
  localparam int unsigned c_FD = 6;
  localparam int unsigned c_FW = c_W * c_H / 4;

  logic            clk = 1'b0;
  logic            nRST = 1'b0;
  logic [31:0]     fifo_data;
  logic [c_FD-1:0] fifo_nb_words;
  logic            fifo_r_e;
  logic [31:0]     base_addr;
  logic            wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]     wb_adr_o, wb_dat_o;
  logic [3:0]      wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic [1:0]      wb_bte_o;
  logic            wb_ack_i, wb_err_i;
  logic            frame_done, wb_error;
`ifdef VIDEO_IN_WB_STATS_EN
  logic [15:0]     frame_cnt;
  logic [7:0]      err_cnt;
`endif

  video_in_wb_writer #(
    .p_WIDTH (c_W),
    .p_HEIGHT(c_H),
    .p_BURST (c_B),
    .p_FDEPTH(c_FD)
  ) dut (
    .clk          (clk),
    .nRST         (nRST),
    .fifo_data    (fifo_data),
    .fifo_nb_words(fifo_nb_words),
    .fifo_r_e     (fifo_r_e),
    .base_addr    (base_addr),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_we_o      (wb_we_o),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_sel_o     (wb_sel_o),
    .wb_cti_o     (wb_cti_o),
    .wb_bte_o     (wb_bte_o),
    .wb_ack_i     (wb_ack_i),
    .wb_err_i     (wb_err_i),
    .frame_done   (frame_done),
    .wb_error     (wb_error)
`ifdef VIDEO_IN_WB_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int n);
    return 32'h3C00_0000 ^ (32'(n) * 32'h0101_0107);
  endfunction

  // FIFO model: head word is a function of how many words were popped.
  int pop_idx = 0;
  assign fifo_data = pat(pop_idx);
  always @(posedge clk) if (fifo_r_e) pop_idx <= pop_idx + 1;

  // Slave model: ack every cycle or every third cycle, optional error beat and beat limit.
  int ack_mode  = 0;
  int ack_limit = 1000;
  int err_beat  = -1;
  int drv_beat  = 0;
  initial begin : slave
    int  wait_cnt;
    bit  issued;
    bit  go;
    wait_cnt = 0;
    issued   = 1'b0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (issued) drv_beat++;
      if (wb_stb_o === 1'b1) begin
        go = (ack_mode == 0) || (wait_cnt == 2);
        if (drv_beat >= ack_limit) go = 1'b0;
        wb_ack_i = go;
        wb_err_i = go && (drv_beat == err_beat);
        issued   = go;
        wait_cnt = go ? 0 : wait_cnt + 1;
      end else begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        issued   = 1'b0;
        drv_beat = 0;
        wait_cnt = 0;
      end
    end
  end

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } beat_t;
  beat_t exp_q[$];

  // Monitor: compares every accepted beat against the scoreboard queue.
  int          fd_count = 0;
  int          mw = 0;
  int          mbeat = 0;
  bit          exp_fd = 1'b0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_adr, prev_dat;
  logic [2:0]  prev_cti;
  always @(negedge clk) begin
    beat_t e;
    if (!nRST) begin
      mw        = 0;
      mbeat     = 0;
      exp_fd    = 1'b0;
      prev_wait = 1'b0;
    end else begin
      if (frame_done) fd_count++;
      if (frame_done || exp_fd) chk("frame_done", 32'(frame_done), 32'(exp_fd));
      exp_fd = 1'b0;
      if (wb_cyc_o && wb_stb_o) begin
        if (prev_wait) begin
          chk("wait_adr_hold", wb_adr_o, prev_adr);
          chk("wait_dat_hold", wb_dat_o, prev_dat);
          chk("wait_cti_hold", 32'(wb_cti_o), 32'(prev_cti));
        end
        if (wb_err_i) begin
          chk("err_no_pop", 32'(fifo_r_e), 32'd0);
          mbeat = 0;
        end else if (wb_ack_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat_adr", wb_adr_o, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("beat_adr", wb_adr_o, e.adr);
            chk("beat_dat", wb_dat_o, e.dat);
          end
          chk("beat_cti", 32'(wb_cti_o), (mbeat == c_B - 1) ? 32'h7 : 32'h2);
          chk("beat_pop", 32'(fifo_r_e), 32'd1);
          chk("beat_we_sel", {27'd0, wb_we_o, wb_sel_o}, 32'h1F);
          mbeat = (mbeat == c_B - 1) ? 0 : mbeat + 1;
          mw++;
          if (mw == c_FW) begin
            mw     = 0;
            exp_fd = 1'b1;
          end
        end else begin
          chk("wait_no_pop", 32'(fifo_r_e), 32'd0);
        end
        prev_wait = !wb_ack_i && !wb_err_i;
        prev_adr  = wb_adr_o;
        prev_dat  = wb_dat_o;
        prev_cti  = wb_cti_o;
      end else begin
        prev_wait = 1'b0;
        mbeat     = 0;
        if (fifo_r_e) chk("idle_no_pop", 32'(fifo_r_e), 32'd0);
      end
    end
  end

  logic [31:0] exp_addr;
  int          exp_pop = 0;

  task automatic push_beats(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{adr: exp_addr, dat: pat(exp_pop)});
      exp_addr += 32'd4;
      exp_pop++;
    end
  endtask

  // Expects a burst of n accepted beats; level is raised for one cycle only.
  task automatic do_burst(input int n);
    int p0;
    push_beats(n);
    p0 = pop_idx;
    fifo_nb_words = c_FD'(8);
    @(posedge clk);
    #1;
    chk("burst_start_cyc", 32'(wb_cyc_o), 32'd1);
    fifo_nb_words = c_FD'(7);
    for (int k = 0; k < 300 && wb_cyc_o; k++) begin
      @(posedge clk);
      #1;
    end
    chk("burst_end_cyc", 32'(wb_cyc_o), 32'd0);
    chk("pops_per_burst", 32'(pop_idx - p0), 32'(n));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cyc_stb_we"}, {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    chk({tag, "_cti_bte"}, {27'd0, wb_cti_o, wb_bte_o}, 32'd0);
    chk({tag, "_sel"}, 32'(wb_sel_o), 32'hF);
    chk({tag, "_pop_fd_err"}, {29'd0, fifo_r_e, frame_done, wb_error}, 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int fd0;
    base_addr     = 32'h1000_0000;
    fifo_nb_words = '0;
    exp_addr      = 32'h1000_0000;
    nRST          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("reset_adr", wb_adr_o, 32'd0);
    nRST = 1'b1;

    // 1: single burst at base address, ack every cycle
    do_burst(8);

    // 2: level below burst size holds the bus idle
    fifo_nb_words = c_FD'(7);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("level7_idle", {30'd0, wb_cyc_o, fifo_r_e}, 32'd0);
    end
    chk("level7_no_pops", 32'(pop_idx), 32'd8);
    do_burst(8);

    // 3: ack every third cycle
    ack_mode = 1;
    do_burst(8);
    ack_mode = 0;

    // 4: finish the frame; base changes mid-frame and is used after frame end
    fd0 = fd_count;
    for (int b = 0; b < 29; b++) begin
      if (b == 10) base_addr = 32'h2000_0000;
      do_burst(8);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("frame_done_count", 32'(fd_count - fd0), 32'd1);
    chk("no_error_yet", 32'(wb_error), 32'd0);

    // 5: error (with ack) on beat 3, then resume at the first unacked word
    exp_addr = 32'h2000_0000;
    err_beat = 3;
    do_burst(3);
    err_beat = -1;
    chk("wb_error_sticky", 32'(wb_error), 32'd1);
    do_burst(8);
    chk("wb_error_still_set", 32'(wb_error), 32'd1);

    // 6: reset during a stalled burst at beat 5
    ack_limit = 5;
    push_beats(5);
    fifo_nb_words = c_FD'(8);
    @(posedge clk);
    #1;
    fifo_nb_words = c_FD'(7);
    for (int k = 0; k < 50 && drv_beat < 5; k++) begin
      @(posedge clk);
      #1;
    end
    chk("stall_beats", 32'(drv_beat), 32'd5);
    repeat (2) @(posedge clk);
    #1;
    chk("stalled_cyc", 32'(wb_cyc_o), 32'd1);
    nRST = 1'b0;
    #1;
    chk_reset_outputs("midburst_reset");
    base_addr = 32'h3000_0000;
    ack_limit = 1000;
    @(posedge clk);
    #1;
    nRST     = 1'b1;
    exp_addr = 32'h3000_0000;
    fd0      = fd_count;
    for (int b = 0; b < 32; b++) do_burst(8);
    repeat (2) @(posedge clk);
    #1;
    chk("frame_after_reset", 32'(fd_count - fd0), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_video_in_wb_writer
`default_nettype wire
